// File: rtl/stopwatch_pkg.sv
// Shared constants for the mm:ss stopwatch controller: FSM state codes
// and BCD digit limits.
package stopwatch_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_LAP   = 2'b11;

    localparam logic [3:0] BCD_MAX_ONES = 4'd9;
    localparam logic [3:0] BCD_MAX_TENS = 4'd5;

endpackage

// File: rtl/stopwatch_ctrl_bcd_mmss_counter.sv
// BCD mm:ss time counter. Advances one second per inc, rolls 59:59 over
// to 00:00 with a one-cycle wrap pulse. clr has priority over inc and
// suppresses wrap.
module bcd_mmss_counter
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic       wrap
);

    logic [3:0] sec_o, sec_t, min_o, min_t;
    logic [3:0] sec_o_n, sec_t_n, min_o_n, min_t_n;
    logic       wrap_n;

    // Next-time logic: ripple carry through the four BCD digits.
    always_comb begin
        sec_o_n = sec_o;
        sec_t_n = sec_t;
        min_o_n = min_o;
        min_t_n = min_t;
        wrap_n  = 1'b0;
        if (clr) begin
            sec_o_n = 4'd0;
            sec_t_n = 4'd0;
            min_o_n = 4'd0;
            min_t_n = 4'd0;
        end else if (inc) begin
            if (sec_o != BCD_MAX_ONES) begin
                sec_o_n = sec_o + 4'd1;
            end else begin
                sec_o_n = 4'd0;
                if (sec_t != BCD_MAX_TENS) begin
                    sec_t_n = sec_t + 4'd1;
                end else begin
                    sec_t_n = 4'd0;
                    if (min_o != BCD_MAX_ONES) begin
                        min_o_n = min_o + 4'd1;
                    end else begin
                        min_o_n = 4'd0;
                        if (min_t != BCD_MAX_TENS) begin
                            min_t_n = min_t + 4'd1;
                        end else begin
                            min_t_n = 4'd0;
                            wrap_n  = 1'b1;
                        end
                    end
                end
            end
        end else begin
            wrap_n = 1'b0;
        end
    end

    // Time and wrap registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_o <= 4'd0;
            sec_t <= 4'd0;
            min_o <= 4'd0;
            min_t <= 4'd0;
            wrap  <= 1'b0;
        end else begin
            sec_o <= sec_o_n;
            sec_t <= sec_t_n;
            min_o <= min_o_n;
            min_t <= min_t_n;
            wrap  <= wrap_n;
        end
    end

    assign min = {min_t, min_o};
    assign sec = {sec_t, sec_o};

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear controller for the mm:ss stopwatch. Holds the FSM,
// the 1 s prescaler, the lap snapshot and the live/snapshot display mux.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_p,
    input  logic       lap_p,
    input  logic       clr_p,
    output logic       count_en,
    output logic [1:0] state,
    output logic       lap_active,
    output logic [7:0] disp_min,
    output logic [7:0] disp_sec,
    output logic       wrap
);

    localparam int             PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]  PRESC_ONE  = PW'(1);

    logic [1:0]    state_n;
    logic          lap_capture;
    logic [PW-1:0] presc;
    logic          tick;
    logic [7:0]    live_min, live_sec;
    logic [7:0]    snap_min, snap_sec;

    // Moore decodes of the registered state.
    assign count_en   = (state == ST_RUN) || (state == ST_LAP);
    assign lap_active = (state == ST_LAP);
    assign tick       = count_en && (presc == PRESC_LAST);

    // Next-state logic; clr beats start beats lap, only the winner acts.
    always_comb begin
        state_n     = state;
        lap_capture = 1'b0;
        if (clr_p) begin
            state_n = ST_IDLE;
        end else if (start_p) begin
            case (state)
                ST_IDLE:  state_n = ST_RUN;
                ST_RUN:   state_n = ST_PAUSE;
                ST_LAP:   state_n = ST_PAUSE;
                ST_PAUSE: state_n = ST_RUN;
                default:  state_n = ST_IDLE;
            endcase
        end else if (lap_p) begin
            case (state)
                ST_RUN: begin
                    state_n     = ST_LAP;
                    lap_capture = 1'b1;
                end
                ST_LAP:   state_n = ST_RUN;
                ST_IDLE:  state_n = ST_IDLE;
                ST_PAUSE: state_n = ST_PAUSE;
                default:  state_n = ST_IDLE;
            endcase
        end else begin
            state_n = state;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Prescaler: runs only while counting, holds in PAUSE, zeroed on clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (clr_p) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else if (count_en) begin
            presc <= presc + PRESC_ONE;
        end else begin
            presc <= presc;
        end
    end

    // Lap snapshot: captures the pre-increment live time on entry to LAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_min <= 8'h00;
            snap_sec <= 8'h00;
        end else if (clr_p) begin
            snap_min <= 8'h00;
            snap_sec <= 8'h00;
        end else if (lap_capture) begin
            snap_min <= live_min;
            snap_sec <= live_sec;
        end else begin
            snap_min <= snap_min;
            snap_sec <= snap_sec;
        end
    end

    bcd_mmss_counter u_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_p),
        .inc  (tick),
        .min  (live_min),
        .sec  (live_sec),
        .wrap (wrap)
    );

    // Display selects between registered sources, so it follows state with no lag.
    assign disp_min = lap_active ? snap_min : live_min;
    assign disp_sec = lap_active ? snap_sec : live_sec;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl with TICK_DIV=4.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_p, lap_p, clr_p;
    logic       count_en, lap_active, wrap;
    logic [1:0] state;
    logic [7:0] disp_min, disp_sec;

    int n_checks = 0;
    int n_pass   = 0;

    stopwatch_ctrl #(.TICK_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_p    (start_p),
        .lap_p      (lap_p),
        .clr_p      (clr_p),
        .count_en   (count_en),
        .state      (state),
        .lap_active (lap_active),
        .disp_min   (disp_min),
        .disp_sec   (disp_sec),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    // Advance n clock edges; returns 1 time unit after the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic s, input logic l, input logic c);
        start_p = s;
        lap_p   = l;
        clr_p   = c;
        step(1);
        start_p = 1'b0;
        lap_p   = 1'b0;
        clr_p   = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({state, count_en, lap_active, wrap, disp_min, disp_sec} !== 21'd0)
            $display("FAIL reset_state: got st=%b en=%b lap=%b wrap=%b disp=%h:%h want all zero",
                     state, count_en, lap_active, wrap, disp_min, disp_sec);
        else n_pass++;
        // Async reset mid-count, between clock edges.
        pulse(1'b1, 1'b0, 1'b0);
        step(6);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({state, count_en, disp_min, disp_sec} !== 19'd0)
            $display("FAIL async_reset: got st=%b en=%b disp=%h:%h want 00 0 00:00",
                     state, count_en, disp_min, disp_sec);
        else n_pass++;
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_run_pause();
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        step(12);
        n_checks++;
        if ({disp_min, disp_sec} !== 16'h0003)
            $display("FAIL run_12clk: got %h want %h", {disp_min, disp_sec}, 16'h0003);
        else n_pass++;
        pulse(1'b1, 1'b0, 1'b0);
        step(20);
        n_checks++;
        if ({state, count_en, disp_min, disp_sec} !== {2'b10, 1'b0, 16'h0003})
            $display("FAIL pause_hold: got st=%b en=%b disp=%h want 10 0 0003",
                     state, count_en, {disp_min, disp_sec});
        else n_pass++;
        // Prescaler held at 1, so two more edges keep 00:03 and the third ticks.
        pulse(1'b1, 1'b0, 1'b0);
        step(2);
        n_checks++;
        if ({state, disp_min, disp_sec} !== {2'b01, 16'h0003})
            $display("FAIL resume_partial: got st=%b disp=%h want 01 0003",
                     state, {disp_min, disp_sec});
        else n_pass++;
        step(1);
        n_checks++;
        if ({disp_min, disp_sec} !== 16'h0004)
            $display("FAIL resume_tick: got %h want %h", {disp_min, disp_sec}, 16'h0004);
        else n_pass++;
    endtask

    task automatic test_lap();
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        step(20);
        pulse(1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({state, lap_active, count_en, disp_min, disp_sec} !== {2'b11, 1'b1, 1'b1, 16'h0005})
            $display("FAIL lap_enter: got st=%b lap=%b en=%b disp=%h want 11 1 1 0005",
                     state, lap_active, count_en, {disp_min, disp_sec});
        else n_pass++;
        step(11);
        n_checks++;
        if ({disp_min, disp_sec} !== 16'h0005)
            $display("FAIL lap_frozen: got %h want %h", {disp_min, disp_sec}, 16'h0005);
        else n_pass++;
        pulse(1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({state, lap_active, disp_min, disp_sec} !== {2'b01, 1'b0, 16'h0008})
            $display("FAIL lap_exit: got st=%b lap=%b disp=%h want 01 0 0008",
                     state, lap_active, {disp_min, disp_sec});
        else n_pass++;
    endtask

    task automatic test_full_hour();
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        step(236);
        n_checks++;
        if ({disp_min, disp_sec} !== 16'h0059)
            $display("FAIL t_0059: got %h want %h", {disp_min, disp_sec}, 16'h0059);
        else n_pass++;
        step(4);
        n_checks++;
        if ({disp_min, disp_sec} !== 16'h0100)
            $display("FAIL t_0100: got %h want %h", {disp_min, disp_sec}, 16'h0100);
        else n_pass++;
        step(2156);
        n_checks++;
        if ({disp_min, disp_sec} !== 16'h0959)
            $display("FAIL t_0959: got %h want %h", {disp_min, disp_sec}, 16'h0959);
        else n_pass++;
        step(4);
        n_checks++;
        if ({disp_min, disp_sec} !== 16'h1000)
            $display("FAIL t_1000: got %h want %h", {disp_min, disp_sec}, 16'h1000);
        else n_pass++;
        step(11996);
        n_checks++;
        if ({disp_min, disp_sec, wrap} !== {16'h5959, 1'b0})
            $display("FAIL t_5959: got %h wrap=%b want 5959 wrap=0",
                     {disp_min, disp_sec}, wrap);
        else n_pass++;
        step(4);
        n_checks++;
        if ({disp_min, disp_sec, wrap} !== {16'h0000, 1'b1})
            $display("FAIL t_wrap: got %h wrap=%b want 0000 wrap=1",
                     {disp_min, disp_sec}, wrap);
        else n_pass++;
        step(1);
        n_checks++;
        if (wrap !== 1'b0)
            $display("FAIL wrap_pulse: got wrap=%b want 0", wrap);
        else n_pass++;
    endtask

    task automatic test_priority();
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        step(6);
        pulse(1'b1, 1'b0, 1'b1);
        n_checks++;
        if ({state, count_en, disp_min, disp_sec} !== {2'b00, 1'b0, 16'h0000})
            $display("FAIL clr_over_start: got st=%b en=%b disp=%h want 00 0 0000",
                     state, count_en, {disp_min, disp_sec});
        else n_pass++;
        pulse(1'b1, 1'b0, 1'b0);
        step(4);
        pulse(1'b1, 1'b1, 1'b0);
        n_checks++;
        if ({state, lap_active, count_en, disp_min, disp_sec} !== {2'b10, 1'b0, 1'b0, 16'h0001})
            $display("FAIL start_over_lap: got st=%b lap=%b en=%b disp=%h want 10 0 0 0001",
                     state, lap_active, count_en, {disp_min, disp_sec});
        else n_pass++;
    endtask

    task automatic test_edge_ticks();
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        step(39);
        pulse(1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({state, disp_min, disp_sec} !== {2'b11, 16'h0009})
            $display("FAIL lap_on_tick: got st=%b disp=%h want 11 0009",
                     state, {disp_min, disp_sec});
        else n_pass++;
        pulse(1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({disp_min, disp_sec} !== 16'h0010)
            $display("FAIL live_after_lap: got %h want %h", {disp_min, disp_sec}, 16'h0010);
        else n_pass++;
        step(2);
        pulse(1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({state, disp_min, disp_sec, wrap} !== {2'b00, 16'h0000, 1'b0})
            $display("FAIL clr_on_tick: got st=%b disp=%h wrap=%b want 00 0000 0",
                     state, {disp_min, disp_sec}, wrap);
        else n_pass++;
        // Prescaler must restart from zero after the clear.
        pulse(1'b1, 1'b0, 1'b0);
        step(3);
        n_checks++;
        if ({disp_min, disp_sec} !== 16'h0000)
            $display("FAIL presc_cleared: got %h want %h", {disp_min, disp_sec}, 16'h0000);
        else n_pass++;
        step(1);
        n_checks++;
        if ({disp_min, disp_sec} !== 16'h0001)
            $display("FAIL first_tick_after_clr: got %h want %h", {disp_min, disp_sec}, 16'h0001);
        else n_pass++;
    endtask

    initial begin
        rst     = 1'b1;
        start_p = 1'b0;
        lap_p   = 1'b0;
        clr_p   = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_run_pause();
        test_lap();
        test_full_hour();
        test_priority();
        test_edge_ticks();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
